// File: rtl/mem_stage.sv
// RV32I memory stage: turns execute-stage loads/stores into single-beat data
// memory requests and returns sign/zero-extended load results for writeback.
module mem_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDRESS    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ls_valid,
    output logic                  ls_ready,
    input  logic                  ls_we,
    input  logic [2:0]            funct3,
    input  logic [ADDRESS-1:0]    alu_addr,
    input  logic [DATA_WIDTH-1:0] store_data,
    input  logic [4:0]            rd_in,
    output logic                  data_mem_request,
    output logic                  data_mem_we_re,
    output logic [3:0]            data_mem_mask,
    output logic [ADDRESS-1:0]    data_mem_addr,
    output logic [DATA_WIDTH-1:0] data_mem_wdata,
    input  logic                  data_mem_valid,
    input  logic [DATA_WIDTH-1:0] data_mem_rdata,
    output logic                  wb_valid,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic [4:0]            wb_rd,
    output logic                  ls_done,
    output logic                  ls_error
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;

    // Operation captured at accept; needed later to pick the load lane.
    logic       we_q;
    logic [2:0] funct3_q;
    logic [1:0] off_q;
    logic [4:0] rd_q;

    logic                  misaligned;
    logic                  bad_funct3;
    logic                  op_error;
    logic [3:0]            mask_next;
    logic [DATA_WIDTH-1:0] wdata_next;

    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // through the case leaves it unassigned and infers a latch.
        misaligned = 1'b0;
        bad_funct3 = 1'b0;
        mask_next  = 4'b0000;
        wdata_next = store_data;
        case (funct3[1:0])
            2'b00: begin
                mask_next  = 4'b0001 << alu_addr[1:0];
                wdata_next = {4{store_data[7:0]}};
            end
            2'b01: begin
                misaligned = alu_addr[0];
                mask_next  = alu_addr[1] ? 4'b1100 : 4'b0011;
                wdata_next = {2{store_data[15:0]}};
            end
            2'b10: begin
                misaligned = |alu_addr[1:0];
                mask_next  = 4'b1111;
            end
            default: bad_funct3 = 1'b1;
        endcase
        // Stores have no unsigned variants; loads have no unsigned word.
        if (ls_we && funct3[2]) begin
            bad_funct3 = 1'b1;
        end
        if (!ls_we && funct3[2] && funct3[1]) begin
            bad_funct3 = 1'b1;
        end
    end

    assign op_error = misaligned || bad_funct3;

    logic [DATA_WIDTH-1:0] lane_shifted;
    logic [DATA_WIDTH-1:0] load_value;

    assign lane_shifted = data_mem_rdata >> {off_q, 3'b000};

    always_comb begin
        load_value = lane_shifted;
        case (funct3_q)
            3'b000:  load_value = {{24{lane_shifted[7]}}, lane_shifted[7:0]};
            3'b001:  load_value = {{16{lane_shifted[15]}}, lane_shifted[15:0]};
            3'b100:  load_value = {24'd0, lane_shifted[7:0]};
            3'b101:  load_value = {16'd0, lane_shifted[15:0]};
            default: load_value = lane_shifted;
        endcase
    end

    assign ls_ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state            <= IDLE;
            we_q             <= 1'b0;
            funct3_q         <= 3'd0;
            off_q            <= 2'd0;
            rd_q             <= 5'd0;
            data_mem_request <= 1'b0;
            data_mem_we_re   <= 1'b0;
            data_mem_mask    <= 4'd0;
            data_mem_addr    <= '0;
            data_mem_wdata   <= '0;
            wb_valid         <= 1'b0;
            wb_data          <= '0;
            wb_rd            <= 5'd0;
            ls_done          <= 1'b0;
            ls_error         <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register in this block updates from its pre-edge value.
            ls_done  <= 1'b0;
            wb_valid <= 1'b0;
            ls_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (ls_valid) begin
                        we_q     <= ls_we;
                        funct3_q <= funct3;
                        off_q    <= alu_addr[1:0];
                        rd_q     <= rd_in;
                        if (op_error) begin
                            ls_error <= 1'b1;
                        end else begin
                            state            <= WAIT;
                            data_mem_request <= 1'b1;
                            data_mem_we_re   <= ls_we;
                            data_mem_mask    <= mask_next;
                            data_mem_addr    <= {alu_addr[ADDRESS-1:2], 2'b00};
                            data_mem_wdata   <= wdata_next;
                        end
                    end
                end
                WAIT: begin
                    if (data_mem_valid) begin
                        state            <= RESP;
                        data_mem_request <= 1'b0;
                        ls_done          <= 1'b1;
                        if (!we_q) begin
                            wb_valid <= 1'b1;
                            wb_data  <= load_value;
                            wb_rd    <= rd_q;
                        end
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a memory responder checks requests, and a
// response monitor checks ls_error/ls_done/wb pulses against queued expectations.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ls_valid;
    logic        ls_ready;
    logic        ls_we;
    logic [2:0]  funct3;
    logic [31:0] alu_addr;
    logic [31:0] store_data;
    logic [4:0]  rd_in;
    logic        data_mem_request;
    logic        data_mem_we_re;
    logic [3:0]  data_mem_mask;
    logic [31:0] data_mem_addr;
    logic [31:0] data_mem_wdata;
    logic        data_mem_valid;
    logic [31:0] data_mem_rdata;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        ls_done;
    logic        ls_error;

    mem_stage #(.DATA_WIDTH(32), .ADDRESS(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .ls_valid         (ls_valid),
        .ls_ready         (ls_ready),
        .ls_we            (ls_we),
        .funct3           (funct3),
        .alu_addr         (alu_addr),
        .store_data       (store_data),
        .rd_in            (rd_in),
        .data_mem_request (data_mem_request),
        .data_mem_we_re   (data_mem_we_re),
        .data_mem_mask    (data_mem_mask),
        .data_mem_addr    (data_mem_addr),
        .data_mem_wdata   (data_mem_wdata),
        .data_mem_valid   (data_mem_valid),
        .data_mem_rdata   (data_mem_rdata),
        .wb_valid         (wb_valid),
        .wb_data          (wb_data),
        .wb_rd            (wb_rd),
        .ls_done          (ls_done),
        .ls_error         (ls_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [3:0]  mask;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;
    } req_t;

    typedef struct {
        logic        err;
        logic        load;
        logic [31:0] data;
        logic [4:0]  rd;
        int          cyc;
    } resp_t;

    req_t  req_q[$];
    resp_t resp_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pulse_req = 0;
    int pulse_done = 0;
    logic manual = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        check(name, {31'd0, act}, {31'd0, exp});
    endtask

    // Memory model: checks each request for its whole lifetime, answers after
    // the queued delay, and can also inject a stray data_mem_valid on demand.
    initial begin
        req_t r;
        data_mem_valid = 1'b0;
        data_mem_rdata = 32'hA5A5_A5A5;
        forever begin
            @(negedge clk);
            if (pulse_req != pulse_done) begin
                pulse_done++;
                data_mem_valid = 1'b1;
                data_mem_rdata = 32'h1234_5678;
                @(posedge clk);
                #1;
                data_mem_valid = 1'b0;
                data_mem_rdata = 32'hA5A5_A5A5;
            end else if (data_mem_request === 1'b1 && !manual) begin
                if (req_q.size() == 0) begin
                    check_bit("unexpected_req", data_mem_request, 1'b0);
                end else begin
                    r = req_q.pop_front();
                    for (int i = 0; i <= r.delay; i++) begin
                        if (i > 0) @(negedge clk);
                        check_bit("req_held", data_mem_request, 1'b1);
                        check_bit("req_we", data_mem_we_re, r.we);
                        check("req_mask", {28'd0, data_mem_mask}, {28'd0, r.mask});
                        check("req_addr", data_mem_addr, r.addr);
                        check("req_wdata", data_mem_wdata, r.wdata);
                    end
                    data_mem_valid = 1'b1;
                    data_mem_rdata = r.rdata;
                    @(posedge clk);
                    #1;
                    data_mem_valid = 1'b0;
                    data_mem_rdata = 32'hA5A5_A5A5;
                    @(negedge clk);
                    check_bit("req_drop", data_mem_request, 1'b0);
                end
            end
        end
    end

    // Response monitor: every completion/error pulse must match the next expectation.
    initial begin
        resp_t e;
        forever begin
            @(negedge clk);
            if (ls_done === 1'b1 || ls_error === 1'b1 || wb_valid === 1'b1) begin
                if (resp_q.size() == 0) begin
                    check("unexpected_resp", {29'd0, ls_done, ls_error, wb_valid}, 32'd0);
                end else begin
                    e = resp_q.pop_front();
                    check_bit("resp_error", ls_error, e.err);
                    check_bit("resp_done", ls_done, !e.err);
                    check_bit("resp_wb_valid", wb_valid, e.load);
                    check("resp_cycle", cyc, e.cyc);
                    if (e.load) begin
                        check("resp_wb_data", wb_data, e.data);
                        check("resp_wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
                    end
                end
            end
        end
    end

    // Presents one operation for a single accepted edge and queues what it
    // should produce. Response cycle is counted from the accept edge.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] sdata, input logic [4:0] rd, input logic exp_err,
                         input logic [3:0] exp_mask, input logic [31:0] exp_wdata,
                         input int delay, input logic [31:0] rdata,
                         input logic [31:0] exp_wb, input logic track);
        int    guard = 0;
        int    acc;
        req_t  r;
        resp_t e;
        do begin
            @(posedge clk);
            #1;
            guard++;
        end while (!ls_ready && guard < 200);
        if (!ls_ready) begin
            check_bit("ready_timeout", ls_ready, 1'b1);
            return;
        end
        ls_valid   = 1'b1;
        ls_we      = we;
        funct3     = f3;
        alu_addr   = addr;
        store_data = sdata;
        rd_in      = rd;
        @(posedge clk);
        #1;
        acc      = cyc;
        ls_valid = 1'b0;
        if (track) begin
            e.err  = exp_err;
            e.load = !we && !exp_err;
            e.data = exp_wb;
            e.rd   = rd;
            e.cyc  = exp_err ? acc : acc + 1 + delay;
            if (!exp_err) begin
                r.we    = we;
                r.mask  = exp_mask;
                r.addr  = {addr[31:2], 2'b00};
                r.wdata = exp_wdata;
                r.rdata = rdata;
                r.delay = delay;
                req_q.push_back(r);
            end
            resp_q.push_back(e);
        end
    endtask

    task automatic drain();
        int guard = 0;
        while ((resp_q.size() != 0 || req_q.size() != 0 || !ls_ready) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("drain_resp", resp_q.size(), 32'd0);
        check("drain_req", req_q.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b0;
        ls_valid   = 1'b0;
        ls_we      = 1'b0;
        funct3     = 3'd0;
        alu_addr   = 32'd0;
        store_data = 32'd0;
        rd_in      = 5'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_bit("rst_ready", ls_ready, 1'b1);
        check_bit("rst_request", data_mem_request, 1'b0);
        check_bit("rst_we_re", data_mem_we_re, 1'b0);
        check("rst_mask", {28'd0, data_mem_mask}, 32'd0);
        check("rst_addr", data_mem_addr, 32'd0);
        check("rst_wdata", data_mem_wdata, 32'd0);
        check("rst_pulses", {29'd0, wb_valid, ls_done, ls_error}, 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        //     we    f3      addr          sdata          rd  err mask     wdata          dly rdata          wb
        issue(1'b0, 3'b010, 32'h0000_0100, 32'h0,         5,  0, 4'b1111, 32'h0,         0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1);
        issue(1'b0, 3'b000, 32'h0000_0103, 32'h0,         6,  0, 4'b1000, 32'h0,         0, 32'h80FF_0000, 32'hFFFF_FF80, 1);
        issue(1'b0, 3'b100, 32'h0000_0103, 32'h0,         7,  0, 4'b1000, 32'h0,         1, 32'h80FF_0000, 32'h0000_0080, 1);
        issue(1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 9,  0, 4'b1100, 32'hABCD_ABCD, 0, 32'hFFFF_FFFF, 32'h0,         1);
        drain();
        @(negedge clk);
        check("hold_wb_data", wb_data, 32'h0000_0080);
        check("hold_wb_rd", {27'd0, wb_rd}, 32'd7);

        // Misaligned word: error pulse only, no request, still ready.
        issue(1'b0, 3'b010, 32'h0000_0101, 32'h0,         4,  1, 4'b0000, 32'h0,         0, 32'h0,         32'h0,         1);
        @(negedge clk);
        check_bit("err_no_request", data_mem_request, 1'b0);
        check_bit("err_ready", ls_ready, 1'b1);

        // Slow memory: request held for five cycles before the answer.
        issue(1'b0, 3'b001, 32'h0000_0010, 32'h0,         10, 0, 4'b0011, 32'h0,         4, 32'h5A5A_8001, 32'hFFFF_8001, 1);
        issue(1'b1, 3'b000, 32'h0000_0007, 32'h1234_56A5, 11, 0, 4'b1000, 32'hA5A5_A5A5, 1, 32'hFFFF_FFFF, 32'h0,         1);
        issue(1'b0, 3'b101, 32'h0000_0006, 32'h0,         31, 0, 4'b1100, 32'h0,         2, 32'hBEEF_1234, 32'h0000_BEEF, 1);
        issue(1'b1, 3'b010, 32'h0000_0020, 32'hCAFE_F00D, 12, 0, 4'b1111, 32'hCAFE_F00D, 0, 32'hFFFF_FFFF, 32'h0,         1);
        issue(1'b0, 3'b000, 32'h0000_0001, 32'h0,         1,  0, 4'b0010, 32'h0,         0, 32'h0000_7F00, 32'h0000_007F, 1);

        // Illegal funct3 and misaligned halfword/word forms.
        issue(1'b0, 3'b011, 32'h0000_0000, 32'h0,         2,  1, 4'b0000, 32'h0,         0, 32'h0,         32'h0,         1);
        issue(1'b0, 3'b110, 32'h0000_0000, 32'h0,         2,  1, 4'b0000, 32'h0,         0, 32'h0,         32'h0,         1);
        issue(1'b1, 3'b100, 32'h0000_0000, 32'h0,         2,  1, 4'b0000, 32'h0,         0, 32'h0,         32'h0,         1);
        issue(1'b1, 3'b001, 32'h0000_0001, 32'h0,         2,  1, 4'b0000, 32'h0,         0, 32'h0,         32'h0,         1);
        issue(1'b0, 3'b001, 32'h0000_0003, 32'h0,         2,  1, 4'b0000, 32'h0,         0, 32'h0,         32'h0,         1);
        issue(1'b1, 3'b010, 32'h0000_0002, 32'h0,         2,  1, 4'b0000, 32'h0,         0, 32'h0,         32'h0,         1);
        drain();

        // A stray completion while idle must be ignored.
        pulse_req++;
        repeat (3) begin
            @(negedge clk);
            check_bit("idle_valid_no_done", ls_done, 1'b0);
            check_bit("idle_valid_ready", ls_ready, 1'b1);
        end

        // Reset while waiting abandons the load; a late completion is ignored.
        manual = 1'b1;
        issue(1'b0, 3'b010, 32'h0000_0040, 32'h0,         3,  0, 4'b1111, 32'h0,         0, 32'h0,         32'h0,         0);
        @(negedge clk);
        check_bit("rstw_request", data_mem_request, 1'b1);
        check_bit("rstw_busy", ls_ready, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check_bit("rstw_req_drop", data_mem_request, 1'b0);
        check_bit("rstw_ready", ls_ready, 1'b1);
        check("rstw_wb_data", wb_data, 32'd0);
        pulse_req++;
        repeat (4) begin
            @(negedge clk);
            check_bit("rstw_no_wb", wb_valid, 1'b0);
            check_bit("rstw_no_done", ls_done, 1'b0);
        end
        check_bit("rstw_final_ready", ls_ready, 1'b1);
        manual = 1'b0;

        check("final_resp_q", resp_q.size(), 32'd0);
        check("final_req_q", req_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
